ntt_intt_coeff_loader: RTL and testbench



---
 rtl/ntt_intt_loader_pkg.sv | 45 ++++
 rtl/ntt_intt_coeff_fifo.sv | 83 ++++++++
 rtl/ntt_intt_coeff_loader.sv | 196 +++++++++++++++++++
 tb/tb_ntt_intt_coeff_loader.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_intt_loader_pkg.sv
// Shared definitions for the NTT/INTT coefficient loader.
// Holds the OBI request/response structs, register selects decoded from addr[3:2],
// STATUS field positions, the default polynomial geometry and the packed
// coefficient-pair typedef.
package ntt_intt_loader_pkg;

    // Kyber defaults: q = 3329 fits in 12 bits, 256 coefficients per polynomial.
    localparam int unsigned KYBER_COEFF_W = 12;
    localparam int unsigned KYBER_NCOEFF  = 256;
    localparam int unsigned NWORDS        = KYBER_NCOEFF / 2;

    // Register select taken from addr[3:2].
    typedef enum logic [1:0] {
        RegLoad   = 2'd0,
        RegResult = 2'd1,
        RegStatus = 2'd2,
        RegCtrl   = 2'd3
    } reg_sel_e;

    // STATUS word layout.
    localparam int unsigned STATUS_ERR_BIT    = 31;
    localparam int unsigned STATUS_UNLOAD_LSB = 16;
    localparam int unsigned STATUS_LEVEL_LSB  = 8;
    localparam int unsigned STATUS_LOAD_LSB   = 0;

    typedef struct packed {
        logic [KYBER_COEFF_W-1:0] hi;
        logic [KYBER_COEFF_W-1:0] lo;
    } coeff_pair_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/ntt_intt_coeff_fifo.sv
// Synchronous FIFO for packed coefficient pairs, no fall-through.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clear_i            synchronous flush, wins over push/pop
//   push_i/push_data_i write side (ignored when full)
//   pop_i/pop_data_o   read side, head entry always presented (ignored when empty)
//   full_o, empty_o    occupancy flags
//   level_o            number of stored entries
module ntt_intt_coeff_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    // DEPTH is a power of two, so the level MSB alone marks full.
    assign full_o     = level_q[AW];
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_d = level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only visible through level_q.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/ntt_intt_coeff_loader.sv
// OBI slave between the bus and the NTT/INTT datapath.
// LOAD writes push coefficient pairs into a FIFO feeding the load stream; RESULT reads
// pop the datapath result stream; STATUS reports err and the counters; CTRL clears.
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   slave_req_i / slave_resp_o       OBI request / response (gnt combinational,
//                                    rvalid+rdata registered one cycle after gnt)
//   coeff_valid_o/ready_i/data_o     load stream {hi, lo}
//   res_valid_i/ready_o/data_i       result stream {hi, lo}
//   load_done_o, unload_done_o       one-cycle pulse per whole polynomial
module ntt_intt_coeff_loader
    import ntt_intt_loader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned COEFF_W    = KYBER_COEFF_W,
    parameter int unsigned NCOEFF     = KYBER_NCOEFF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  obi_req_t             slave_req_i,
    output obi_resp_t            slave_resp_o,
    output logic                 coeff_valid_o,
    input  logic                 coeff_ready_i,
    output logic [2*COEFF_W-1:0] coeff_data_o,
    input  logic                 res_valid_i,
    output logic                 res_ready_o,
    input  logic [2*COEFF_W-1:0] res_data_i,
    output logic                 load_done_o,
    output logic                 unload_done_o
);
    localparam int unsigned POLY_WORDS = NCOEFF / 2;
    localparam int unsigned CNT_W      = $clog2(POLY_WORDS);
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PAIR_W     = 2 * COEFF_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLY_WORDS - 1);

    reg_sel_e          sel;
    logic              gnt, push, clear, res_pop, err_set, stream_pop;
    logic              fifo_full, fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic [PAIR_W-1:0] push_data;
    logic [31:0]       rdata_d, rdata_q;
    logic [31:0]       status_word, result_word;
    logic              rvalid_q;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d, unload_cnt_q, unload_cnt_d;
    logic              load_done_q, load_done_d, unload_done_q, unload_done_d;
    logic              unused_req;

    // Address bits outside [3:2] and wdata bits outside the coefficient fields are don't-care.
    assign unused_req = ^{slave_req_i.addr, slave_req_i.wdata};

    assign sel        = reg_sel_e'(slave_req_i.addr[3:2]);
    assign push_data  = {slave_req_i.wdata[16 +: COEFF_W], slave_req_i.wdata[0 +: COEFF_W]};
    assign stream_pop = coeff_valid_o && coeff_ready_i;

    always_comb begin
        result_word = '0;
        result_word[0 +: COEFF_W]  = res_data_i[0 +: COEFF_W];
        result_word[16 +: COEFF_W] = res_data_i[PAIR_W-1 -: COEFF_W];

        status_word = '0;
        status_word[STATUS_ERR_BIT]          = err_q;
        status_word[STATUS_UNLOAD_LSB +: 8]  = 8'(unload_cnt_q);
        status_word[STATUS_LEVEL_LSB +: 8]   = 8'(fifo_level);
        status_word[STATUS_LOAD_LSB +: 8]    = 8'(load_cnt_q);
    end

    // Decode: every legal or illegal access gets a grant; only LOAD writes (FIFO full)
    // and RESULT reads (no result available) can stall.
    always_comb begin
        gnt     = 1'b0;
        push    = 1'b0;
        clear   = 1'b0;
        res_pop = 1'b0;
        err_set = 1'b0;
        rdata_d = '0;
        if (slave_req_i.req) begin
            unique case (sel)
                RegLoad: begin
                    if (slave_req_i.we) begin
                        gnt = !fifo_full;
                        if (slave_req_i.be == 4'hF) begin
                            push = gnt;
                        end else begin
                            err_set = gnt;
                        end
                    end else begin
                        gnt     = 1'b1;
                        err_set = 1'b1;
                    end
                end
                RegResult: begin
                    if (!slave_req_i.we) begin
                        gnt     = res_valid_i;
                        res_pop = res_valid_i;
                        rdata_d = result_word;
                    end else begin
                        gnt     = 1'b1;
                        err_set = 1'b1;
                    end
                end
                RegStatus: begin
                    gnt = 1'b1;
                    if (!slave_req_i.we) begin
                        rdata_d = status_word;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                RegCtrl: begin
                    gnt = 1'b1;
                    if (slave_req_i.we) begin
                        clear = slave_req_i.wdata[0];
                    end else begin
                        err_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counters and err; a clear in the same cycle overrides any count and suppresses done.
    always_comb begin
        load_cnt_d    = load_cnt_q;
        unload_cnt_d  = unload_cnt_q;
        load_done_d   = 1'b0;
        unload_done_d = 1'b0;
        err_d         = err_q | err_set;
        if (clear) begin
            load_cnt_d   = '0;
            unload_cnt_d = '0;
            err_d        = 1'b0;
        end else begin
            if (stream_pop) begin
                load_done_d = (load_cnt_q == CNT_LAST);
                load_cnt_d  = load_done_d ? '0 : load_cnt_q + 1'b1;
            end
            if (res_pop) begin
                unload_done_d = (unload_cnt_q == CNT_LAST);
                unload_cnt_d  = unload_done_d ? '0 : unload_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            load_cnt_q    <= '0;
            unload_cnt_q  <= '0;
            load_done_q   <= 1'b0;
            unload_done_q <= 1'b0;
        end else begin
            rvalid_q      <= gnt;
            if (gnt) begin
                rdata_q <= rdata_d;
            end
            err_q         <= err_d;
            load_cnt_q    <= load_cnt_d;
            unload_cnt_q  <= unload_cnt_d;
            load_done_q   <= load_done_d;
            unload_done_q <= unload_done_d;
        end
    end

    ntt_intt_coeff_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAIR_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (stream_pop),
        .pop_data_o  (coeff_data_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    assign coeff_valid_o = !fifo_empty;
    assign res_ready_o   = res_pop;
    assign load_done_o   = load_done_q;
    assign unload_done_o = unload_done_q;

    always_comb begin
        slave_resp_o.gnt    = gnt;
        slave_resp_o.rvalid = rvalid_q;
        slave_resp_o.rdata  = rdata_q;
    end

endmodule

// File: tb/tb_ntt_intt_coeff_loader.sv
`timescale 1ns/1ps
module tb_ntt_intt_coeff_loader;
    import ntt_intt_loader_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WORDS = NWORDS;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    obi_req_t    bus_req;
    obi_resp_t   bus_resp;
    logic        coeff_valid, coeff_ready;
    logic [23:0] coeff_data;
    logic        res_valid, res_ready;
    logic [23:0] res_data;
    logic        load_done, unload_done;

    always #5 clk = ~clk;

    ntt_intt_coeff_loader #(
        .FIFO_DEPTH (DEPTH),
        .COEFF_W    (12),
        .NCOEFF     (256)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .slave_req_i   (bus_req),
        .slave_resp_o  (bus_resp),
        .coeff_valid_o (coeff_valid),
        .coeff_ready_i (coeff_ready),
        .coeff_data_o  (coeff_data),
        .res_valid_i   (res_valid),
        .res_ready_o   (res_ready),
        .res_data_i    (res_data),
        .load_done_o   (load_done),
        .unload_done_o (unload_done)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: queue of pending load words, counters, sticky err.
    logic [23:0] mq[$];
    int          m_load_cnt = 0;
    int          m_unload_cnt = 0;
    bit          m_err = 1'b0;
    // Effects scheduled for the coming clock edge.
    bit          p_gnt, p_push, p_clear, p_unload, p_err, p_pop;
    logic [23:0] p_push_data;
    bit          exp_rvalid, exp_load_done, exp_unload_done;
    bit          mon_en = 1'b0;
    int          load_pulses = 0;
    int          unload_pulses = 0;

    task automatic model_reset();
        mq.delete();
        m_load_cnt = 0; m_unload_cnt = 0; m_err = 1'b0;
        p_gnt = 0; p_push = 0; p_clear = 0; p_unload = 0; p_err = 0; p_pop = 0;
        exp_rvalid = 0; exp_load_done = 0; exp_unload_done = 0;
    endtask

    // Output checks between edges; also decide whether the stream pops at the next edge.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            n_cmp++;
            if (coeff_valid !== (mq.size() != 0)) begin
                n_fail++; $display("FAIL coeff_valid: got %b want %b", coeff_valid, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                n_cmp++;
                if (coeff_data !== mq[0]) begin
                    n_fail++; $display("FAIL coeff_data: got %h want %h", coeff_data, mq[0]);
                end
            end
            n_cmp++;
            if (bus_resp.rvalid !== exp_rvalid) begin
                n_fail++; $display("FAIL rvalid: got %b want %b", bus_resp.rvalid, exp_rvalid);
            end
            n_cmp++;
            if (load_done !== exp_load_done) begin
                n_fail++; $display("FAIL load_done: got %b want %b", load_done, exp_load_done);
            end
            n_cmp++;
            if (unload_done !== exp_unload_done) begin
                n_fail++; $display("FAIL unload_done: got %b want %b", unload_done, exp_unload_done);
            end
            if (load_done === 1'b1) load_pulses++;
            if (unload_done === 1'b1) unload_pulses++;
            p_pop = coeff_ready && (mq.size() != 0);
        end
    end

    // Apply the scheduled effects at each edge.
    initial forever begin
        @(posedge clk);
        if (mon_en) begin
            exp_rvalid = p_gnt;
            exp_load_done = 0;
            exp_unload_done = 0;
            if (p_clear) begin
                mq.delete();
                m_load_cnt = 0; m_unload_cnt = 0; m_err = 1'b0;
            end else begin
                if (p_pop) begin
                    void'(mq.pop_front());
                    exp_load_done = (m_load_cnt == WORDS - 1);
                    m_load_cnt = (m_load_cnt + 1) % WORDS;
                end
                if (p_push) mq.push_back(p_push_data);
                if (p_unload) begin
                    exp_unload_done = (m_unload_cnt == WORDS - 1);
                    m_unload_cnt = (m_unload_cnt + 1) % WORDS;
                end
                if (p_err) m_err = 1'b1;
            end
            p_gnt = 0; p_push = 0; p_clear = 0; p_unload = 0; p_err = 0; p_pop = 0;
        end
    end

    function automatic logic [31:0] model_status();
        logic [7:0] lc, uc, lv;
        lc = 8'(m_load_cnt);
        uc = 8'(m_unload_cnt);
        lv = 8'(mq.size());
        return {m_err, 7'b0, uc, lv, lc};
    endfunction

    // One bus access, held until granted or max_wait cycles; returns at posedge+1.
    task automatic bus(input bit we, input logic [3:0] be, input logic [1:0] sel,
                       input logic [31:0] wdata, input int max_wait,
                       output bit granted, output logic [31:0] rdata);
        bit          exp_gnt;
        logic [31:0] exp_rdata;
        logic [31:0] addr;
        granted   = 0;
        rdata     = '0;
        exp_rdata = '0;
        addr      = $urandom();
        addr[3:2] = sel;
        @(negedge clk);
        bus_req.req = 1'b1; bus_req.we = we; bus_req.be = be;
        bus_req.addr = addr; bus_req.wdata = wdata;
        for (int i = 0; i < max_wait; i++) begin
            #1;
            if (sel == 2'd0 && we) exp_gnt = (mq.size() < DEPTH);
            else if (sel == 2'd1 && !we) exp_gnt = res_valid;
            else exp_gnt = 1'b1;
            n_cmp++;
            if (bus_resp.gnt !== exp_gnt) begin
                n_fail++; $display("FAIL gnt sel=%0d we=%0b: got %b want %b", sel, we, bus_resp.gnt, exp_gnt);
            end
            n_cmp++;
            if (res_ready !== (exp_gnt && sel == 2'd1 && !we)) begin
                n_fail++; $display("FAIL res_ready: got %b want %b", res_ready, exp_gnt && sel == 2'd1 && !we);
            end
            if (exp_gnt) begin
                p_gnt = 1;
                case (sel)
                    2'd0: if (!we) p_err = 1;
                          else if (be == 4'hF) begin p_push = 1; p_push_data = {wdata[27:16], wdata[11:0]}; end
                          else p_err = 1;
                    2'd1: if (we) p_err = 1;
                          else begin p_unload = 1; exp_rdata = {4'b0, res_data[23:12], 4'b0, res_data[11:0]}; end
                    2'd2: if (we) p_err = 1; else exp_rdata = model_status();
                    default: if (!we) p_err = 1; else p_clear = wdata[0];
                endcase
            end
            if (bus_resp.gnt === 1'b1) begin
                granted = 1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus_req.req = 1'b0;
        if (granted) begin
            rdata = bus_resp.rdata;
            if (!we) begin
                n_cmp++;
                if (rdata !== exp_rdata) begin
                    n_fail++; $display("FAIL rdata sel=%0d: got %h want %h", sel, rdata, exp_rdata);
                end
            end
        end
    endtask

    task automatic do_reset();
        mon_en = 0;
        bus_req = '0;
        coeff_ready = 0;
        res_valid = 0;
        res_data = '0;
        rst_ni = 0;
        #1;
        n_cmp++;
        if ({bus_resp.gnt, bus_resp.rvalid, coeff_valid, res_ready, load_done, unload_done} !== 6'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 000000",
                {bus_resp.gnt, bus_resp.rvalid, coeff_valid, res_ready, load_done, unload_done});
        end
        n_cmp++;
        if (bus_resp.rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 00000000", bus_resp.rdata);
        end
        @(posedge clk);
        #1;
        rst_ni = 1;
        model_reset();
        mon_en = 1;
    endtask

    task automatic test_reset();
        bit g; logic [31:0] rd;
        do_reset();
        bus(1'b0, 4'hF, 2'd2, 32'h0, 2, g, rd);
        n_cmp++;
        if (!g || rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_status: got gnt=%b rdata=%h want gnt=1 rdata=00000000", g, rd);
        end
    endtask

    task automatic test_fifo_full();
        bit g; logic [31:0] rd;
        coeff_ready = 0;
        for (int i = 0; i < 4; i++) begin
            bus(1'b1, 4'hF, 2'd0, 32'h0ABC_0123, 2, g, rd);
            n_cmp++;
            if (!g) begin n_fail++; $display("FAIL full_load_gnt: got 0 want 1"); end
        end
        n_cmp++;
        if (coeff_data !== 24'hABC123) begin
            n_fail++; $display("FAIL full_coeff_data: got %h want abc123", coeff_data);
        end
        bus(1'b0, 4'hF, 2'd2, 32'h0, 2, g, rd);
        n_cmp++;
        if (rd[15:8] !== 8'd4) begin
            n_fail++; $display("FAIL full_level: got %0d want 4", rd[15:8]);
        end
        // Fifth write stalls until a single pop frees a slot.
        fork
            begin
                repeat (3) @(posedge clk);
                #1 coeff_ready = 1;
                @(posedge clk);
                #1 coeff_ready = 0;
            end
            bus(1'b1, 4'hF, 2'd0, 32'h0ABC_0123, 8, g, rd);
        join
        n_cmp++;
        if (!g) begin n_fail++; $display("FAIL full_fifth_gnt: got 0 want 1"); end
        bus(1'b1, 4'hF, 2'd3, 32'h1, 2, g, rd);
    endtask

    task automatic test_stream();
        bit g; logic [31:0] rd;
        load_pulses = 0;
        coeff_ready = 1;
        for (int i = 0; i < int'(WORDS); i++) begin
            bus(1'b1, 4'hF, 2'd0, $urandom(), 3, g, rd);
        end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (load_pulses != 1) begin
            n_fail++; $display("FAIL stream_load_done_pulses: got %0d want 1", load_pulses);
        end
        bus(1'b0, 4'hF, 2'd2, 32'h0, 2, g, rd);
        n_cmp++;
        if (rd[7:0] !== 8'd0) begin
            n_fail++; $display("FAIL stream_load_cnt: got %0d want 0", rd[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        bit g; logic [31:0] rd;
        time t0;
        coeff_ready = 1;
        t0 = $time;
        for (int i = 0; i < 8; i++) bus(1'b1, 4'hF, 2'd0, $urandom(), 1, g, rd);
        n_cmp++;
        if (($time - t0) != 80) begin
            n_fail++; $display("FAIL back_to_back_time: got %0t want 80", $time - t0);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_result();
        bit g; logic [31:0] rd;
        unload_pulses = 0;
        res_valid = 1;
        res_data = 24'hFFF001;
        for (int i = 0; i < int'(WORDS); i++) begin
            bus(1'b0, 4'hF, 2'd1, 32'h0, 2, g, rd);
            n_cmp++;
            if (rd !== 32'h0FFF_0001) begin
                n_fail++; $display("FAIL result_rdata: got %h want 0fff0001", rd);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (unload_pulses != 1) begin
            n_fail++; $display("FAIL result_unload_pulses: got %0d want 1", unload_pulses);
        end
    endtask

    task automatic test_result_stall();
        bit g; logic [31:0] rd;
        res_valid = 0;
        res_data = 24'h123456;
        fork
            begin
                repeat (5) @(posedge clk);
                #1 res_valid = 1;
            end
            bus(1'b0, 4'hF, 2'd1, 32'h0, 10, g, rd);
        join
        n_cmp++;
        if (!g || rd !== 32'h0123_0456) begin
            n_fail++; $display("FAIL stall_result: got gnt=%b rdata=%h want gnt=1 rdata=01230456", g, rd);
        end
    endtask

    task automatic test_err_clear();
        bit g; logic [31:0] rd;
        coeff_ready = 0;
        bus(1'b1, 4'h3, 2'd0, 32'h0555_0666, 2, g, rd);
        bus(1'b0, 4'hF, 2'd3, 32'h0, 2, g, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL err_ctrl_read: got %h want 0", rd); end
        bus(1'b0, 4'hF, 2'd2, 32'h0, 2, g, rd);
        n_cmp++;
        if (rd[31] !== 1'b1 || rd[15:8] !== 8'd0) begin
            n_fail++; $display("FAIL err_status: got %h want err=1 level=0", rd);
        end
        bus(1'b1, 4'hF, 2'd0, 32'h0111_0222, 2, g, rd);
        bus(1'b1, 4'hF, 2'd3, 32'h1, 2, g, rd);
        bus(1'b0, 4'hF, 2'd2, 32'h0, 2, g, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL clear_status: got %h want 0", rd); end
    endtask

    task automatic test_random();
        bit g; logic [31:0] rd;
        logic [1:0] sel;
        logic [3:0] be;
        for (int i = 0; i < 120; i++) begin
            coeff_ready = ($urandom_range(0, 2) != 0);
            res_valid   = ($urandom_range(0, 3) != 0);
            res_data    = 24'($urandom());
            sel         = 2'($urandom_range(0, 3));
            be          = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom());
            // Clear only occasionally so the counters get exercised.
            bus(1'($urandom()), be, sel, $urandom() & ((i % 16 == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE),
                4, g, rd);
        end
        coeff_ready = 0;
        bus(1'b0, 4'hF, 2'd2, 32'h0, 2, g, rd);
    endtask

    task automatic test_reset_mid();
        bit g; logic [31:0] rd;
        coeff_ready = 0;
        bus(1'b1, 4'hF, 2'd3, 32'h1, 2, g, rd);
        bus(1'b1, 4'hF, 2'd0, 32'h0777_0888, 2, g, rd);
        bus(1'b1, 4'hF, 2'd0, 32'h0999_0AAA, 2, g, rd);
        @(negedge clk);
        bus_req.req = 1; bus_req.we = 0; bus_req.be = 4'hF; bus_req.addr = 32'h8;
        @(posedge clk);
        #1;
        bus_req.req = 0;
        mon_en = 0;
        rst_ni = 0;
        #1;
        n_cmp++;
        if (bus_resp.rvalid !== 1'b0 || coeff_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got rvalid=%b valid=%b want 0 0", bus_resp.rvalid, coeff_valid);
        end
        do_reset();
        bus(1'b0, 4'hF, 2'd2, 32'h0, 2, g, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_reset_status: got %h want 0", rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_req = '0;
        coeff_ready = 0;
        res_valid = 0;
        res_data = '0;
        test_reset();
        test_fifo_full();
        test_stream();
        test_back_to_back();
        test_result();
        test_result_stall();
        test_err_clear();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
